// File: rtl/dds_osc_if.sv
// Sample-rate bus of the oscillator: the phase increment and waveform controls
// going in, and the sample with its strobe coming out.
interface dds_osc_if;
  logic [31:0] adder;
  logic [1:0]  wave_sel;
  logic [6:0]  pw;
  logic        sync;
  logic        sample_stb;
  logic [11:0] wave_out;

  modport master (
    output adder, wave_sel, pw, sync,
    input  sample_stb, wave_out
  );

  modport slave (
    input  adder, wave_sel, pw, sync,
    output sample_stb, wave_out
  );
endinterface

// File: rtl/dds_osc.sv
// Phase-accumulator oscillator: divides clk down to the audio sample rate,
// accumulates the per-sample phase increment and shapes one 12-bit unsigned
// sample per period (saw, pulse, triangle, noise) with hard sync.
// Pipeline: tick edge updates acc/lfsr, the following edge registers the
// shaped sample and raises sample_stb for one cycle.
module dds_osc #(
  parameter int unsigned SAMPLE_DIV = 1000
) (
  input logic      clk,
  input logic      rst_n,
  dds_osc_if.slave bus
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  logic [15:0] div_cnt;
  logic        tick;
  logic [31:0] acc;
  logic [15:0] lfsr;
  logic        sync_pend;
  logic        pend;
  logic        tick_d;
  logic        sample_stb_r;
  logic [11:0] wave_r;
  logic [11:0] wave_next;
  logic        lfsr_fb;

  assign tick    = (div_cnt == DIV_LAST);
  assign pend    = sync_pend | bus.sync;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Sample-rate divider: counts 0..SAMPLE_DIV-1, tick on the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Stage 1: phase accumulation, noise shift and sync capture; any number of
  // sync requests inside one period collapse into a single phase reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= 32'h0;
      lfsr      <= 16'hACE1;
      sync_pend <= 1'b0;
      tick_d    <= 1'b0;
    end else begin
      tick_d <= tick;
      if (tick) begin
        sync_pend <= 1'b0;
        acc       <= pend ? 32'h0 : acc + bus.adder;
        lfsr      <= {lfsr[14:0], lfsr_fb};
      end else begin
        sync_pend <= pend;
      end
    end
  end

  // Waveform shaping from the already-updated phase and noise state.
  always_comb begin
    wave_next = 12'h000;
    unique case (bus.wave_sel)
      2'd0: wave_next = acc[31:20];
      2'd1: wave_next = (acc[31:25] < bus.pw) ? 12'hFFF : 12'h000;
      2'd2: wave_next = acc[31] ? ~acc[30:19] : acc[30:19];
      2'd3: wave_next = lfsr[15:4];
      default: wave_next = 12'h000;
    endcase
  end

  // Stage 2: register the sample only on the strobe so the output never
  // moves between samples, even when wave_sel/pw change mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_stb_r <= 1'b0;
      wave_r       <= 12'h000;
    end else begin
      sample_stb_r <= tick_d;
      if (tick_d) begin
        wave_r <= wave_next;
      end
    end
  end

  assign bus.sample_stb = sample_stb_r;
  assign bus.wave_out   = wave_r;

endmodule

// File: tb/tb_dds_osc.sv
// Directed bench for dds_osc: one instance at SAMPLE_DIV=4 for saw, triangle,
// sync and async reset, one at SAMPLE_DIV=1 for pulse and the long noise run.
module tb_dds_osc;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  dds_osc_if bus4 ();
  dds_osc_if bus1 ();

  dds_osc #(.SAMPLE_DIV(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  dds_osc #(.SAMPLE_DIV(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Hold reset over two edges, release 2 ns after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Step edge by edge until the chosen instance shows a strobe; returns the
  // number of edges taken. Leaves time at 1 ns after the strobe edge.
  task automatic wait_stb(input bit which, input string tag, output int edges);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if ((which ? bus1.sample_stb : bus4.sample_stb) === 1'b1) seen = 1'b1;
    end
    if (!seen) chk({tag, "_strobe_seen"}, 32'(seen), 32'd1);
  endtask

  // One-cycle sync pulse on the SAMPLE_DIV=4 instance, n edges from now.
  task automatic pulse_sync(input int n);
    repeat (n) @(posedge clk);
    #1 bus4.sync = 1'b1;
    @(posedge clk);
    #1 bus4.sync = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [11:0] tri_exp [10];
  logic [15:0] m;
  logic [11:0] first_noise;
  int          edges;
  int          bad;
  int          zeros;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus4.adder = 32'h1000_0000; bus4.wave_sel = 2'd0; bus4.pw = 7'd0; bus4.sync = 1'b0;
    bus1.adder = 32'h0800_0000; bus1.wave_sel = 2'd1; bus1.pw = 7'd64; bus1.sync = 1'b0;

    #3;
    chk("reset_wave", 32'(bus4.wave_out), 32'h000);
    chk("reset_stb", 32'(bus4.sample_stb), 32'd0);

    // Saw with wrap, strobe every 4 clocks.
    do_reset();
    wait_stb(1'b0, "saw", edges);
    chk("saw_first_latency", 32'(edges), 32'd5);
    chk("saw_1", 32'(bus4.wave_out), 32'h100);
    for (int k = 2; k <= 17; k++) begin
      wait_stb(1'b0, "saw", edges);
      chk("saw_period", 32'(edges), 32'd4);
      chk($sformatf("saw_%0d", k), 32'(bus4.wave_out), 32'((k % 16) * 256));
    end

    // Triangle.
    tri_exp = '{12'h200, 12'h400, 12'h600, 12'h800, 12'hA00,
                12'hC00, 12'hE00, 12'hFFF, 12'hDFF, 12'hBFF};
    bus4.wave_sel = 2'd2;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      wait_stb(1'b0, "tri", edges);
      chk($sformatf("tri_%0d", k), 32'(bus4.wave_out), 32'(tri_exp[k]));
    end

    // Hard sync.
    bus4.wave_sel = 2'd0;
    do_reset();
    for (int k = 0; k < 5; k++) wait_stb(1'b0, "sync", edges);
    chk("sync_pre", 32'(bus4.wave_out), 32'h500);
    pulse_sync(0);
    wait_stb(1'b0, "sync", edges);
    chk("sync_reset", 32'(bus4.wave_out), 32'h000);
    wait_stb(1'b0, "sync", edges);
    chk("sync_after", 32'(bus4.wave_out), 32'h100);
    pulse_sync(0);
    pulse_sync(0);
    wait_stb(1'b0, "sync", edges);
    chk("sync_double_reset", 32'(bus4.wave_out), 32'h000);
    wait_stb(1'b0, "sync", edges);
    chk("sync_double_after", 32'(bus4.wave_out), 32'h100);
    pulse_sync(2);
    wait_stb(1'b0, "sync", edges);
    chk("sync_in_tick", 32'(bus4.wave_out), 32'h000);
    wait_stb(1'b0, "sync", edges);
    chk("sync_in_tick_after", 32'(bus4.wave_out), 32'h100);

    // Zero increment freezes the phase.
    bus4.adder = 32'h0;
    wait_stb(1'b0, "freeze", edges);
    chk("freeze_1", 32'(bus4.wave_out), 32'h100);
    wait_stb(1'b0, "freeze", edges);
    chk("freeze_2", 32'(bus4.wave_out), 32'h100);

    // Asynchronous reset mid-stream, while the strobe is high.
    bus4.adder = 32'h1000_0000;
    do_reset();
    for (int k = 0; k < 3; k++) wait_stb(1'b0, "areset", edges);
    chk("areset_pre", 32'(bus4.wave_out), 32'h300);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_wave", 32'(bus4.wave_out), 32'h000);
    chk("areset_stb", 32'(bus4.sample_stb), 32'd0);
    bus4.adder = 32'h1234_5678;
    #2 rst_n = 1'b1;
    wait_stb(1'b0, "areset", edges);
    chk("areset_latency", 32'(edges), 32'd5);
    chk("areset_value", 32'(bus4.wave_out), 32'h123);

    // Pulse, 50% duty at SAMPLE_DIV=1.
    do_reset();
    wait_stb(1'b1, "pulse", edges);
    chk("pulse_first_latency", 32'(edges), 32'd2);
    chk("pulse_1", 32'(bus1.wave_out), 32'hFFF);
    for (int k = 2; k <= 32; k++) begin
      wait_stb(1'b1, "pulse", edges);
      chk($sformatf("pulse_%0d", k), 32'(bus1.wave_out),
          (k < 16 || k == 32) ? 32'hFFF : 32'h000);
    end

    // pw = 0 never goes high.
    bus1.pw = 7'd0;
    do_reset();
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      wait_stb(1'b1, "pw0", edges);
      if (bus1.wave_out !== 12'h000) bad++;
    end
    chk("pw0_nonzero_samples", 32'(bad), 32'd0);

    // Noise over one full LFSR period.
    bus1.wave_sel = 2'd3;
    do_reset();
    m     = 16'hACE1;
    bad   = 0;
    zeros = 0;
    first_noise = 12'h000;
    for (int k = 1; k <= 65536; k++) begin
      m = lfsr_step(m);
      if (m == 16'h0) zeros++;
      wait_stb(1'b1, "noise", edges);
      if (k == 1) first_noise = bus1.wave_out;
      if (bus1.wave_out !== m[15:4]) bad++;
    end
    chk("noise_first", 32'(first_noise), 32'h59C);
    chk("noise_wrap", 32'(bus1.wave_out), 32'h59C);
    chk("noise_bad_samples", 32'(bad), 32'd0);
    chk("noise_zero_state", 32'(zeros), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
